mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the byte-select data RAM: turns pipeline MEM-stage load/store requests
//  (lb/lbu/lh/lhu/lw/sb/sh/sw) into RAM port cycles (str, sel, addr, data).
//  Shapes store data into byte lanes, and extracts and sign- or zero-extends load data.
//  Sits between the MEM stage and the data RAM; uses a valid/ready request and a one-cycle response pulse.
// PARAMETERS
//  ADDR_WIDTH  10  RAM word-address width; ram_addr = req_addr[ADDR_WIDTH+1:2]
// PORTS
//  clk         in   1           clock; all state on posedge
//  rst         in   1           synchronous reset, active-high
//  req_valid   in   1           request present
//  req_ready   out  1           unit can accept; high only in IDLE
//  req_we      in   1           1 = store, 0 = load
//  req_size    in   2           0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
//  req_unsigned in  1           loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr    in   32          byte address
//  req_wdata   in   32          store data, right-justified
//  resp_valid  out  1           one-cycle completion pulse (loads and stores)
//  resp_rdata  out  32          extended load data; 0 for stores; held until next resp_valid
//  resp_err    out  1           misalignment trap; valid with resp_valid (tied 0 without macro)
//  ram_str     out  1           RAM write strobe
//  ram_sel     out  4           RAM byte enables; sel[k] covers bits 8k+7:8k
//  ram_addr    out  ADDR_WIDTH  RAM word address
//  ram_data    out  32          RAM write data, lane-replicated
//  ram_result  in   32          RAM combinational read data for ram_addr
// BEHAVIOUR
//  Interface is fixed: one clock; reset is synchronous and active-high (clk, rst).
//  FSM IDLE -> ACCESS -> RESP -> IDLE. rst forces IDLE from any state.
//  - IDLE: req_ready = 1. req_valid & req_ready at an edge latches the request and moves to ACCESS.
//  - ACCESS: drives the RAM from the latched request.
//    - Store: ram_str = 1 and the RAM writes at the exiting edge.
//    - Load: ram_result is extracted and registered into resp_rdata at the exiting edge.
//  - RESP: resp_valid = 1 for exactly one cycle, then IDLE.
//  Latency: accept at edge N, RAM write/read at N+1, resp_valid high in the cycle after N+1.
//  Throughput is one request per 3 cycles.
//  Lane rules, with a = latched addr[1:0]:
//    sel:  byte = 4'b0001<<a;  half = 4'b0011<<{a[1],0};  word = 4'b1111
//    data: byte = {4{wdata[7:0]}};  half = {2{wdata[15:0]}};  word = wdata
//    load: byte = ram_result[8a+7:8a];  half = ram_result[16a[1]+15:16a[1]];  word = ram_result
//    Loads sign- or zero-extend per req_unsigned.
//  ram_sel, ram_addr and ram_data hold their latched values in every state.
//  ram_str = (state == ACCESS) & req_we & !rst & !trap.
//  Reset: rst in ACCESS suppresses the write at that edge.
//  Reset values: req_ready = 0 during rst and 1 after; resp_valid = 0, resp_rdata = 0, resp_err = 0;
//    ram_str = 0, ram_sel = 0, ram_addr = 0, ram_data = 0.
//  Address wrap: req_addr bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo RAM size.
//  req_valid while busy: ignored (req_ready = 0). The requester holds it until accepted.
// CONFIGURATION
//  MEM_ALIGN_TRAP_EN defined:
//    Misaligned means half with a[0] = 1, or word/reserved with a != 0.
//    A misaligned access never asserts ram_str. resp_valid arrives with resp_err = 1 and resp_rdata = 0.
//    Latency is unchanged.
//  MEM_ALIGN_TRAP_EN undefined:
//    Low bits are silently ignored: half uses a[1], word uses lane 0. resp_err is constant 0.
// STRUCTURE
//  Package mem_access_pkg:
//    SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
//    FSM state encoding ST_IDLE/ST_ACCESS/ST_RESP.
//    lane_sel and lane_replicate functions.
//  Sub-module load_extract (combinational): inputs ram_result, a, size, unsigned; output is the 32-bit extended value.
// TESTING
//  1 sw addr 0x10, data 0xDEADBEEF -> ram_str 1 cycle, sel 4'b1111, ram_addr 4; lw 0x10 returns 0xDEADBEEF.
//  2 sb addr 0x13, data 0x80 -> sel 4'b1000, ram_data 0x80808080.
//    Then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
//  3 sh addr 0x22, data 0x1234ABCD -> sel 4'b1100.
//    Then lh 0x22 -> 0xFFFFABCD; lhu 0x22 -> 0x0000ABCD.
//  4 Back-to-back valid -> req_ready low 2 cycles after accept; second request accepted at edge N+3.
//    resp_valid pulses are exactly 1 cycle, 3 cycles apart.
//  5 rst asserted during ACCESS of a sw -> no RAM write (later lw reads old value).
//    req_ready 1 after release; no resp_valid.
//  6 sw addr 0x12:
//    with MEM_ALIGN_TRAP_EN -> resp_err 1, no write.
//    without it -> write to word 4, sel 4'b1111.
//    Addr 0x1010 with ADDR_WIDTH 10 aliases word 4.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants, FSM encoding and byte-lane helpers for mem_access_unit.
// The misalignment check is only consulted when MEM_ALIGN_TRAP_EN is defined.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: lane_sel = 4'b0001 << a;
      SIZE_HALF: lane_sel = 4'b0011 << {a[1], 1'b0};
      default:   lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: lane_replicate = {4{wdata[7:0]}};
      SIZE_HALF: lane_replicate = {2{wdata[15:0]}};
      default:   lane_replicate = wdata;
    endcase
  endfunction

  // Reserved size (3) is handled exactly like a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = a[0];
      default:   misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Combinational load-data lane extraction with sign or zero extension.
module load_extract
  import mem_access_pkg::*;
(
  input  logic [31:0] i_ram_result,
  input  logic [1:0]  i_a,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_a)
      2'd0:    w_byte = i_ram_result[7:0];
      2'd1:    w_byte = i_ram_result[15:8];
      2'd2:    w_byte = i_ram_result[23:16];
      default: w_byte = i_ram_result[31:24];
    endcase
    w_half = i_a[1] ? i_ram_result[31:16] : i_ram_result[15:0];

    case (i_size)
      SIZE_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default:   o_data = i_ram_result;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for the byte-select data RAM.
// Define MEM_ALIGN_TRAP_EN to trap misaligned half/word accesses via resp_err.
//
// state     | meaning
// ST_IDLE   | ready for a request; accept latches it and the RAM port fields
// ST_ACCESS | RAM cycle: store strobes, load data registered at the exit edge
// ST_RESP   | one-cycle resp_valid pulse
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  ram_str,
  output logic [3:0]            ram_sel,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data,
  input  logic [31:0]           ram_result
);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_a;
  logic        w_trap;
  logic [31:0] w_load;

  // Upper address bits alias by design; fold them so they are visibly consumed.
  logic w_unused_addr;
  assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

`ifdef MEM_ALIGN_TRAP_EN
  assign w_trap = misaligned(r_size, r_a);
`else
  assign w_trap = 1'b0;
`endif

  load_extract u_load_extract (
    .i_ram_result (ram_result),
    .i_a          (r_a),
    .i_size       (r_size),
    .i_unsigned   (r_uns),
    .o_data       (w_load)
  );

  assign req_ready  = (r_state == ST_IDLE) & ~rst;
  assign resp_valid = (r_state == ST_RESP) & ~rst;
  assign ram_str    = (r_state == ST_ACCESS) & r_we & ~rst & ~w_trap;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_uns      <= 1'b0;
      r_a        <= 2'b00;
      ram_sel    <= 4'b0000;
      ram_addr   <= '0;
      ram_data   <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && req_valid) begin
        r_we     <= req_we;
        r_size   <= req_size;
        r_uns    <= req_unsigned;
        r_a      <= req_addr[1:0];
        ram_sel  <= lane_sel(req_size, req_addr[1:0]);
        ram_addr <= req_addr[ADDR_WIDTH+1:2];
        ram_data <= lane_replicate(req_size, req_wdata);
      end
      // Stores and trapped accesses report zero data.
      if (r_state == ST_ACCESS) begin
        resp_rdata <= (r_we | w_trap) ? 32'h0 : w_load;
        resp_err   <= w_trap;
      end
    end
  end

endmodule
